// File: rtl/bitty_pkg.sv
// Shared constants and helpers for the bitty fetch sequencer.
package bitty_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_ADVANCE  = 3'd5;

  // Saturating increment for the executed-instruction counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// Execution watchdog: counts enabled cycles since the last clear and flags
// when the count has reached TIMEOUT-1.
module bitty_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Holds at LAST so the counter can never wrap back to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == LAST);

endmodule

// File: rtl/bitty_fetch_ctrl.sv
// Fetch sequencer: reads one instruction per step from synchronous memory,
// hands it to bitty_core via run/done, then advances the PC.
module bitty_fetch_ctrl
  import bitty_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned PROG_LEN = 256,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic [COUNT_W-1:0] instr_count,
  output logic               timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [INSTR_W-1:0] r_instr;
  logic [COUNT_W-1:0] r_count;
  logic               r_run;
  logic               r_rd_en;
  logic               r_busy;
  logic               r_err;
  logic               r_stop_pend;
  logic               r_start_q;
  logic               w_expire;
  logic               w_err_set;
  logic               w_err_clr;

  bitty_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clr      (r_state == S_ISSUE),
    .i_en       ((r_state == S_EXEC) && !done),
    .o_expire_c (w_expire)
  );

  // Next-state logic; done beats a same-cycle watchdog expiry.
  always_comb begin
    w_next    = r_state;
    w_pc_next = (r_pc == LAST_PC) ? '0 : r_pc + ADDR_W'(1);
    w_err_set = (r_state == S_EXEC) && !done && w_expire;
    w_err_clr = (r_state == S_IDLE) && start && r_start_q;
    case (r_state)
      S_IDLE:     if (start && !r_err) w_next = S_FETCH;
      S_FETCH:    w_next = S_WAIT_MEM;
      S_WAIT_MEM: w_next = S_ISSUE;
      S_ISSUE:    w_next = S_EXEC;
      S_EXEC: begin
        if (done) begin
          w_next = S_ADVANCE;
        end else if (w_expire) begin
          w_next = S_IDLE;
        end
      end
      S_ADVANCE:  w_next = (r_stop_pend || stop) ? S_IDLE : S_FETCH;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_count     <= '0;
      r_run       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_run     <= (w_next == S_ISSUE);
      r_rd_en   <= (w_next == S_FETCH);
      r_busy    <= (w_next != S_IDLE);
      r_start_q <= (r_state == S_IDLE) && start;
      if (r_state == S_WAIT_MEM) begin
        r_instr <= mem_data;
      end
      if (r_state == S_ADVANCE) begin
        r_pc    <= w_pc_next;
        r_count <= sat_inc(r_count);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
      if (w_next == S_IDLE) begin
        r_stop_pend <= 1'b0;
      end else if (stop && (r_state != S_IDLE)) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign run         = r_run;
  assign busy        = r_busy;
  assign instr_count = r_count;
  assign timeout_err = r_err;

endmodule
